// File: rtl/lightpipe_pkg.sv
// lightpipe_pkg: shared frame geometry, scheduler state and word slicing for the lightpipe blocks
package lightpipe_pkg;
   localparam int LP_NCH    = 8;
   localparam int LP_WIDTH  = 24;
   localparam int LP_USER_W = 4;
   typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;
   function automatic int word_slice(input int i);
      return i * LP_WIDTH;
   endfunction
endpackage

// File: rtl/lp_edge_sync.sv
// lp_edge_sync: three-flop synchronizer with rising-edge detect for a slow asynchronous clock
module lp_edge_sync (
   input  logic mclk,
   input  logic rst,
   input  logic d_async,
   output logic rise
);
   logic [2:0] ws_q;
   // ws_q[0..2] are ws1..ws3; the edge is taken between the two settled stages
   always_ff @(posedge mclk) ws_q <= rst ? 3'b000 : {ws_q[1:0], d_async};
   assign rise = ws_q[1] & ~ws_q[2];
endmodule

// File: rtl/lightpipe_frame_sched.sv
// lightpipe_frame_sched: stages per-channel samples and hands complete frames to the framer on each wordclock rise
module lightpipe_frame_sched
   import lightpipe_pkg::*;
#(
   parameter int NCH           = LP_NCH,
   parameter int WIDTH         = LP_WIDTH,
   parameter bit UNDERRUN_MUTE = 1'b1
) (
   input  logic                 mclk,
   input  logic                 rst,
   input  logic                 wordclock,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [2:0]           s_chan,
   input  logic [WIDTH-1:0]     s_data,
   input  logic [LP_USER_W-1:0] user_in,
   output logic [NCH*WIDTH-1:0] out_words,
   output logic [LP_USER_W-1:0] out_user,
   output logic                 frame_strobe,
   output logic [15:0]          underrun_cnt,
   output logic                 seq_err,
   input  logic                 clr_status
);
   logic                 rise, acc, hit, done, underrun;
   state_t               state_q, state_d;
   logic [2:0]           idx_q, idx_d;
   logic [NCH*WIDTH-1:0] stage_q, stage_d, words_q, words_d;
   logic [LP_USER_W-1:0] user_q, user_d;
   logic                 strobe_q, err_q, err_d;
   logic [15:0]          underrun_cnt_q, underrun_cnt_d;

   lp_edge_sync u_sync (.mclk(mclk), .rst(rst), .d_async(wordclock), .rise(rise));

   assign s_ready  = state_q == COLLECT;
   assign acc      = s_valid & s_ready;
   assign hit      = s_chan == idx_q;
   assign done     = acc & hit & (idx_q == 3'(NCH - 1));
   assign underrun = rise & (state_q == COLLECT) & ~done;

   // in-order or channel-0 resync samples land at their own channel slot; others are dropped
   always_comb begin
      stage_d = stage_q;
      if (acc && (hit || s_chan == 3'd0)) stage_d[word_slice(int'(s_chan)) +: WIDTH] = s_data;
   end

   // next-state: index, fill state, frame outputs and status; a frame completing on the edge is bypassed straight out
   always_comb begin
      idx_d          = !acc ? idx_q : hit ? (done ? 3'd0 : idx_q + 3'd1) : (s_chan == 3'd0 ? 3'd1 : 3'd0);
      state_d        = (state_q == FULL && rise) ? COLLECT : (done && !rise) ? FULL : state_q;
      user_d         = rise ? user_in : user_q;
      words_d        = !rise ? words_q : !underrun ? stage_d : UNDERRUN_MUTE ? '0 : words_q;
      underrun_cnt_d = clr_status ? 16'd0 : (underrun && underrun_cnt_q != 16'hFFFF) ? underrun_cnt_q + 16'd1 : underrun_cnt_q;
      err_d          = clr_status ? 1'b0 : err_q | (acc & ~hit);
   end

   // registered scheduler state and framer-facing outputs
   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q        <= COLLECT;
         idx_q          <= 3'd0;
         stage_q        <= '0;
         words_q        <= '0;
         user_q         <= '0;
         strobe_q       <= 1'b0;
         underrun_cnt_q <= 16'd0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         stage_q        <= stage_d;
         words_q        <= words_d;
         user_q         <= user_d;
         strobe_q       <= rise;
         underrun_cnt_q <= underrun_cnt_d;
         err_q          <= err_d;
      end
   end

   assign out_words    = words_q;
   assign out_user     = user_q;
   assign frame_strobe = strobe_q;
   assign underrun_cnt = underrun_cnt_q;
   assign seq_err      = err_q;
endmodule
